lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Parametrised load/store unit placed between the core's execute stage and the data-memory port (`io_lsu_*` bus).
- Accepts one memory command at a time and generates word-aligned bus beats with correct byte-lane masks and shifted write data.
- Assembles, lane-aligns and sign/zero-extends read data.
- Splits lane-crossing accesses into two beats and reports misalignment and bus timeouts.

Parameters:
- XLEN, 32: data/address width; NB = XLEN/8 byte lanes; must be 32 or 64.
- MISALIGN_SPLIT, 1: 1 = split lane-crossing accesses into two beats; 0 = flag them as errors.
- TIMEOUT_CYCLES, 0: wait cycles per beat before error; 0 disables the timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  unit idle, command accepted when cmd_valid&&cmd_ready
- cmd_wen  in  1  1 = store, 0 = load
- cmd_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when XLEN=64)
- cmd_signed  in  1  sign-extend load result
- cmd_addr  in  XLEN  byte address
- cmd_wdata  in  XLEN  store data, LSB-justified
- done_valid  out  1  one-cycle completion pulse
- done_rdata  out  XLEN  extended load result; 0 for stores and errors
- done_err  out  1  misaligned (split disabled), illegal size, or timeout; qualified by done_valid
- io_lsu_reqValid  out  1  beat request, held until response
- io_lsu_addr  out  XLEN  lane-aligned beat address (low log2(NB) bits zero)
- io_lsu_wen  out  1  beat is a write
- io_lsu_wdata  out  XLEN  lane-positioned write data
- io_lsu_wmask  out  NB  active byte lanes, driven for loads too
- io_lsu_respValid  in  1  beat response
- io_lsu_rdata  in  XLEN  raw beat read data

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0 except cmd_ready=1.
  - Timeout counter and assembly buffer cleared.
- States: IDLE, BEAT0, BEAT1, DONE.
- Command accept (IDLE, cmd_valid=1):
  - Latch all cmd_* fields.
  - Compute off = addr mod NB and nbytes = 1<<size.
  - Illegal size, or off+nbytes>NB with MISALIGN_SPLIT=0 → DONE with err=1; no bus activity.
  - Otherwise → BEAT0.
- Beat timing:
  - Bus outputs are registered; reqValid rises the cycle after accept.
  - BEAT0 address = addr & ~(NB-1); wmask lanes off..min(off+nbytes,NB)-1; wdata = cmd_wdata << 8*off.
- Response handling:
  - In BEATx, respValid=1 completes the beat; reqValid drops the next cycle.
  - respValid while in IDLE/DONE is ignored.
- Split accesses (off+nbytes>NB):
  - BEAT0 completes → BEAT1.
  - BEAT1 address = BEAT0 address + NB (wraps modulo 2^XLEN); wmask lanes 0..off+nbytes-NB-1; wdata = cmd_wdata >> 8*(NB-off).
  - Between BEAT0 and BEAT1, reqValid is low for exactly one cycle.
- Read assembly:
  - BEAT0 data >> 8*off fills the low bytes.
  - BEAT1 data << 8*(NB-off) fills the remainder.
  - Result is masked to nbytes, then sign-extended from bit 8*nbytes-1 if cmd_signed, else zero-extended.
- Timeout:
  - Counter resets at each beat start and increments each BEATx cycle without respValid.
  - Reaching TIMEOUT_CYCLES → DONE with err=1, rdata=0; reqValid drops.
  - A late respValid is ignored.
- DONE: done_valid=1 for exactly one cycle, then IDLE. cmd_ready=0 in all states except IDLE.
- Latency (aligned, response in the same cycle reqValid first rises):
  - accept cycle N, reqValid N+1, done_valid N+2.
  - Split access: done_valid N+4 minimum.
- Reset mid-beat aborts immediately; no done pulse is issued.

Decomposition:
- Shared package lsu_pkg:
  - lsu_size_e (SZ_B, SZ_H, SZ_W, SZ_D)
  - lsu_state_e
  - size-to-bytes function
- One combinational sub-module lsu_align(XLEN): given off, size, signed, wdata and raw beat data, produces per-beat wmask, shifted wdata, and the extended result.
- The FSM, timeout counter and assembly buffer stay in lsu_ctrl.

Test Plan:
- Aligned load: XLEN=32, lw addr=0x100, rdata=0xDEADBEEF, respValid the first reqValid cycle → io_lsu_addr=0x100, wmask=4'b1111, done_rdata=0xDEADBEEF, done_valid at accept+2.
- Signed byte load: lb addr=0x103, rdata=0x80000000 → wmask=4'b1000, done_rdata=0xFFFFFF80; same access with cmd_signed=0 → 0x00000080.
- Store half: sh addr=0x201, wdata=0x0000ABCD → io_lsu_addr=0x200, wmask=4'b0110, io_lsu_wdata=0x00ABCD00, wen=1.
- Split load: lw addr=0x302 → beat0 0x300 mask 1100 rdata 0x55667788; beat1 0x304 mask 0011 rdata 0x11223344 → done_rdata=0x33445566.
- Error paths:
  - MISALIGN_SPLIT=0, lw 0x302 → done_err=1, reqValid never asserted.
  - TIMEOUT_CYCLES=4, no respValid → done_err=1 after 4 wait cycles, reqValid low after.
- Reset in BEAT1: pull reset low → all outputs 0 asynchronously, cmd_ready=1 after release, no done pulse, next command runs normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// +--------------------------------------------------------------------+
// | lsu_pkg : shared types and helpers for the load/store unit          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input lsu_size_e size);
        return 4'd1 << size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// +--------------------------------------------------------------------+
// | lsu_align : byte-lane masks, write-data shifts, read assembly/ext   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  lsu_size_e                 size,
    input  logic                      sgn,
    input  logic                      second,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdata,
    input  logic [XLEN-1:0]           asm_in,
    output logic [XLEN/8-1:0]         wmask0,
    output logic [XLEN/8-1:0]         wmask1,
    output logic [XLEN-1:0]           wdata0,
    output logic [XLEN-1:0]           wdata1,
    output logic [XLEN-1:0]           asm_out,
    output logic [XLEN-1:0]           result
);

    localparam int NB = XLEN / 8;
    localparam int SW = $clog2(XLEN);

    logic [3:0]      w_nb;
    logic [2*NB-1:0] w_ones;
    logic [2*NB-1:0] w_lanes;
    logic [7:0]      w_sh_lo;
    logic [7:0]      w_sh_hi;
    logic [XLEN-1:0] w_part;
    logic [SW-1:0]   w_sidx;
    logic            w_sbit;

    assign w_nb    = size_bytes(size);
    assign w_sh_lo = 8'({off, 3'b000});
    assign w_sh_hi = 8'(XLEN) - w_sh_lo;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < NB; i++) begin
            w_ones[i] = (i < int'(w_nb));
        end
    end

    // Upper half of the double-width lane vector is what spills into beat 1
    assign w_lanes = w_ones << off;
    assign wmask0  = w_lanes[NB-1:0];
    assign wmask1  = w_lanes[2*NB-1:NB];
    assign wdata0  = wdata << w_sh_lo;
    assign wdata1  = wdata >> w_sh_hi;

    assign w_part  = second ? (rdata << w_sh_hi) : (rdata >> w_sh_lo);
    assign asm_out = second ? (asm_in | w_part) : w_part;

    assign w_sidx  = SW'({w_nb, 3'b000} - 7'd1);
    assign w_sbit  = asm_out[w_sidx];

    always_comb begin
        result = '0;
        for (int i = 0; i < XLEN; i++) begin
            result[i] = (i < 8 * int'(w_nb)) ? asm_out[i] : (sgn & w_sbit);
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// +--------------------------------------------------------------------+
// | lsu_ctrl : load/store unit FSM between execute and data-memory bus  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int MISALIGN_SPLIT = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wen,
    input  logic [1:0]        cmd_size,
    input  logic              cmd_signed,
    input  logic [XLEN-1:0]   cmd_addr,
    input  logic [XLEN-1:0]   cmd_wdata,
    output logic              done_valid,
    output logic [XLEN-1:0]   done_rdata,
    output logic              done_err,
    output logic              io_lsu_reqValid,
    output logic [XLEN-1:0]   io_lsu_addr,
    output logic              io_lsu_wen,
    output logic [XLEN-1:0]   io_lsu_wdata,
    output logic [XLEN/8-1:0] io_lsu_wmask,
    input  logic              io_lsu_respValid,
    input  logic [XLEN-1:0]   io_lsu_rdata
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_e      state, state_next;
    logic            r_wen, r_sgn;
    lsu_size_e       r_size;
    logic [OW-1:0]   r_off;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_buf;
    logic [TW-1:0]   r_tcnt;

    logic            w_idle, w_accept, w_beat_ok, w_tout, w_cross, w_bad;
    logic [OW-1:0]   w_off;
    lsu_size_e       w_size;
    logic [XLEN-1:0] w_wdata_src;
    logic [NB-1:0]   w_wmask0, w_wmask1;
    logic [XLEN-1:0] w_wdata0, w_wdata1, w_asm, w_result;

    // While idle the aligner looks at the incoming command, otherwise at the latched one
    assign w_idle      = (state == ST_IDLE);
    assign w_off       = w_idle ? cmd_addr[OW-1:0] : r_off;
    assign w_size      = w_idle ? lsu_size_e'(cmd_size) : r_size;
    assign w_wdata_src = w_idle ? cmd_wdata : r_wdata;
    assign w_cross     = (int'(w_off) + int'(size_bytes(w_size))) > NB;
    assign w_bad       = ((XLEN == 32) && (w_size == SZ_D)) || (w_cross && (MISALIGN_SPLIT == 0));

    assign cmd_ready   = w_idle;
    assign done_valid  = (state == ST_DONE);

    lsu_align #(.XLEN(XLEN)) u_align (
        .off     (w_off),
        .size    (w_size),
        .sgn     (r_sgn),
        .second  (state == ST_BEAT1),
        .wdata   (w_wdata_src),
        .rdata   (io_lsu_rdata),
        .asm_in  (r_buf),
        .wmask0  (w_wmask0),
        .wmask1  (w_wmask1),
        .wdata0  (w_wdata0),
        .wdata1  (w_wdata1),
        .asm_out (w_asm),
        .result  (w_result)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        w_accept   = 1'b0;
        w_beat_ok  = 1'b0;
        w_tout     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept   = 1'b1;
                    state_next = w_bad ? ST_DONE : ST_BEAT0;
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (io_lsu_reqValid) begin
                    if (io_lsu_respValid) begin
                        w_beat_ok  = 1'b1;
                        state_next = ((state == ST_BEAT0) && w_cross) ? ST_BEAT1 : ST_DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_tcnt == TLAST)) begin
                        w_tout     = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wen           <= 1'b0;
            r_sgn           <= 1'b0;
            r_size          <= SZ_B;
            r_off           <= '0;
            r_wdata         <= '0;
            r_buf           <= '0;
            r_tcnt          <= '0;
            done_rdata      <= '0;
            done_err        <= 1'b0;
            io_lsu_reqValid <= 1'b0;
            io_lsu_addr     <= '0;
            io_lsu_wen      <= 1'b0;
            io_lsu_wdata    <= '0;
            io_lsu_wmask    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wen   <= cmd_wen;
                        r_sgn   <= cmd_signed;
                        r_size  <= lsu_size_e'(cmd_size);
                        r_off   <= cmd_addr[OW-1:0];
                        r_wdata <= cmd_wdata;
                        r_buf   <= '0;
                        r_tcnt  <= '0;
                        if (w_bad) begin
                            done_err   <= 1'b1;
                            done_rdata <= '0;
                        end else begin
                            io_lsu_reqValid <= 1'b1;
                            io_lsu_addr     <= {cmd_addr[XLEN-1:OW], {OW{1'b0}}};
                            io_lsu_wen      <= cmd_wen;
                            io_lsu_wdata    <= w_wdata0;
                            io_lsu_wmask    <= w_wmask0;
                        end
                    end
                end
                ST_BEAT0, ST_BEAT1: begin
                    if (!io_lsu_reqValid) begin
                        // One idle cycle between the two halves of a split access
                        io_lsu_reqValid <= 1'b1;
                        r_tcnt          <= '0;
                    end else if (w_beat_ok) begin
                        r_buf           <= w_asm;
                        r_tcnt          <= '0;
                        io_lsu_reqValid <= 1'b0;
                        if (state_next == ST_BEAT1) begin
                            io_lsu_addr  <= io_lsu_addr + XLEN'(NB);
                            io_lsu_wdata <= w_wdata1;
                            io_lsu_wmask <= w_wmask1;
                        end else begin
                            done_rdata   <= r_wen ? '0 : w_result;
                            done_err     <= 1'b0;
                            io_lsu_addr  <= '0;
                            io_lsu_wen   <= 1'b0;
                            io_lsu_wdata <= '0;
                            io_lsu_wmask <= '0;
                        end
                    end else if (w_tout) begin
                        done_rdata      <= '0;
                        done_err        <= 1'b1;
                        io_lsu_reqValid <= 1'b0;
                        io_lsu_addr     <= '0;
                        io_lsu_wen      <= 1'b0;
                        io_lsu_wdata    <= '0;
                        io_lsu_wmask    <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_rdata <= '0;
                    done_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_lsu_ctrl : vector table + scoreboard bench for lsu_ctrl          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_lsu_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_valid_ns = 1'b0;
    logic        cmd_wen = 1'b0, cmd_signed = 1'b0;
    logic [1:0]  cmd_size = 2'd0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        resp = 1'b0;
    logic [31:0] rdata = '0;

    logic        cmd_ready, done_valid, done_err, req, wen;
    logic [31:0] done_rdata, addr, wdata;
    logic [3:0]  wmask;
    logic        cmd_ready_ns, done_valid_ns, done_err_ns, req_ns, wen_ns;
    logic [31:0] done_rdata_ns, addr_ns, wdata_ns;
    logic [3:0]  wmask_ns;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    lsu_ctrl #(.XLEN(32), .MISALIGN_SPLIT(1), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wen(cmd_wen),
        .cmd_size(cmd_size), .cmd_signed(cmd_signed), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .done_valid(done_valid), .done_rdata(done_rdata),
        .done_err(done_err), .io_lsu_reqValid(req), .io_lsu_addr(addr),
        .io_lsu_wen(wen), .io_lsu_wdata(wdata), .io_lsu_wmask(wmask),
        .io_lsu_respValid(resp), .io_lsu_rdata(rdata)
    );

    lsu_ctrl #(.XLEN(32), .MISALIGN_SPLIT(0), .TIMEOUT_CYCLES(0)) dut_ns (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid_ns), .cmd_ready(cmd_ready_ns), .cmd_wen(cmd_wen),
        .cmd_size(cmd_size), .cmd_signed(cmd_signed), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .done_valid(done_valid_ns), .done_rdata(done_rdata_ns),
        .done_err(done_err_ns), .io_lsu_reqValid(req_ns), .io_lsu_addr(addr_ns),
        .io_lsu_wen(wen_ns), .io_lsu_wdata(wdata_ns), .io_lsu_wmask(wmask_ns),
        .io_lsu_respValid(resp), .io_lsu_rdata(rdata)
    );

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr, wdata, rd0, rd1;
        int          nbeats;
        logic [31:0] a0;
        logic [3:0]  m0;
        logic [31:0] w0, a1;
        logic [3:0]  m1;
        logic [31:0] w1, exp_rdata;
        logic        exp_err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(posedge clock) begin
        #1;
        if (done_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_rdata", done_rdata, e.rdata);
                chk("done_err", done_err, e.err);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_wen    = v.wen;
        cmd_size   = v.size;
        cmd_signed = v.sgn;
        cmd_addr   = v.addr;
        cmd_wdata  = v.wdata;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, cyc: cyc + v.lat});
        tick();
        cmd_valid = 1'b0;
        for (int b = 0; b < v.nbeats; b++) begin
            n = 0;
            while (!req && n < 50) begin tick(); n++; end
            chk(b == 0 ? "req_rise_wait" : "beat_gap_wait", n, b == 0 ? 0 : 1);
            chk("beat_addr", addr, b == 0 ? v.a0 : v.a1);
            chk("beat_wmask", wmask, b == 0 ? v.m0 : v.m1);
            chk("beat_wdata", wdata, b == 0 ? v.w0 : v.w1);
            chk("beat_wen", wen, v.wen);
            resp  = 1'b1;
            rdata = (b == 0) ? v.rd0 : v.rd1;
            tick();
            resp  = 1'b0;
            chk("req_drop", req, 0);
        end
        if (v.nbeats == 0) chk("no_req_on_error", req, 0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        //        wen sz sgn addr          wdata         rd0           rd1           nb a0            m0     w0            a1            m1     w1            exp           err lat
        vecs[0]  = '{0, 2, 0, 32'h100,      32'h0,        32'hDEADBEEF, 32'h0,        1, 32'h100,      4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        32'hDEADBEEF, 0, 2};
        vecs[1]  = '{0, 0, 1, 32'h103,      32'h0,        32'h80000000, 32'h0,        1, 32'h100,      4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFFFF80, 0, 2};
        vecs[2]  = '{0, 0, 0, 32'h103,      32'h0,        32'h80000000, 32'h0,        1, 32'h100,      4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00000080, 0, 2};
        vecs[3]  = '{1, 1, 0, 32'h201,      32'h0000ABCD, 32'h12345678, 32'h0,        1, 32'h200,      4'h6, 32'h00ABCD00, 32'h0,        4'h0, 32'h0,        32'h0,        0, 2};
        vecs[4]  = '{0, 2, 0, 32'h302,      32'h0,        32'h55667788, 32'h11223344, 2, 32'h300,      4'hC, 32'h0,        32'h304,      4'h3, 32'h0,        32'h33445566, 0, 4};
        vecs[5]  = '{0, 1, 1, 32'h102,      32'h0,        32'h80010000, 32'h0,        1, 32'h100,      4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF8001, 0, 2};
        vecs[6]  = '{1, 2, 0, 32'h203,      32'hAABBCCDD, 32'h0,        32'h0,        2, 32'h200,      4'h8, 32'hDD000000, 32'h204,      4'h7, 32'h00AABBCC, 32'h0,        0, 4};
        vecs[7]  = '{0, 1, 1, 32'h3,        32'h0,        32'hFE000000, 32'hAABBCCFF, 2, 32'h0,        4'h8, 32'h0,        32'h4,        4'h1, 32'h0,        32'hFFFFFFFE, 0, 4};
        vecs[8]  = '{0, 2, 0, 32'hFFFFFFFE, 32'h0,        32'h12340000, 32'h00005678, 2, 32'hFFFFFFFC, 4'hC, 32'h0,        32'h0,        4'h3, 32'h0,        32'h56781234, 0, 4};
        vecs[9]  = '{0, 3, 0, 32'h100,      32'h0,        32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 1};
        vecs[10] = '{0, 0, 0, 32'h101,      32'h0,        32'h0000A500, 32'h0,        1, 32'h100,      4'h2, 32'h0,        32'h0,        4'h0, 32'h0,        32'h000000A5, 0, 2};
        vecs[11] = '{0, 1, 0, 32'h100,      32'h0,        32'h1234F00F, 32'h0,        1, 32'h100,      4'h3, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000F00F, 0, 2};
        vecs[12] = '{1, 0, 0, 32'h102,      32'h123456EF, 32'h0,        32'h0,        1, 32'h100,      4'h4, 32'h56EF0000, 32'h0,        4'h0, 32'h0,        32'h0,        0, 2};

        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_req", req, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_err", done_err, 0);
        chk("rst_done_rdata", done_rdata, 0);
        chk("rst_bus", {addr, wdata, wmask, wen}, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Timeout: no response, request held for exactly four cycles
        cmd_valid = 1'b1; cmd_wen = 1'b0; cmd_size = 2'd2; cmd_signed = 1'b0;
        cmd_addr = 32'h100; cmd_wdata = 32'h0;
        sb.push_back('{rdata: 32'h0, err: 1'b1, cyc: cyc + 5});
        tick();
        cmd_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (req) cnt++;
            tick();
        end
        chk("timeout_req_cycles", cnt, 4);
        chk("timeout_req_low", req, 0);
        resp = 1'b1; rdata = 32'hCAFEF00D;
        tick();
        resp = 1'b0;
        repeat (3) tick();

        // Split disabled: misaligned word errors out without touching the bus
        chk("ns_ready", cmd_ready_ns, 1);
        cmd_valid_ns = 1'b1; cmd_size = 2'd2; cmd_signed = 1'b0; cmd_addr = 32'h302;
        tick();
        cmd_valid_ns = 1'b0;
        chk("ns_done_valid", done_valid_ns, 1);
        chk("ns_done_err", done_err_ns, 1);
        chk("ns_done_rdata", done_rdata_ns, 0);
        chk("ns_req", req_ns, 0);
        tick();
        chk("ns_done_once", done_valid_ns, 0);
        chk("ns_req_after", req_ns, 0);
        tick();
        cmd_valid_ns = 1'b1; cmd_size = 2'd1; cmd_signed = 1'b1; cmd_addr = 32'h102;
        tick();
        cmd_valid_ns = 1'b0;
        chk("ns_aligned_req", req_ns, 1);
        chk("ns_aligned_mask", wmask_ns, 4'hC);
        resp = 1'b1; rdata = 32'h7FFF0000;
        tick();
        resp = 1'b0;
        chk("ns_aligned_done", done_valid_ns, 1);
        chk("ns_aligned_rdata", done_rdata_ns, 32'h00007FFF);
        chk("ns_aligned_err", done_err_ns, 0);
        repeat (2) tick();

        // Reset while the second beat of a split load is outstanding
        cmd_valid = 1'b1; cmd_size = 2'd2; cmd_signed = 1'b0; cmd_addr = 32'h302;
        tick();
        cmd_valid = 1'b0;
        resp = 1'b1; rdata = 32'h55667788;
        tick();
        resp = 1'b0;
        tick();
        chk("rstmid_beat1_req", req, 1);
        #3;
        reset = 1'b0;
        #1;
        chk("rstmid_req", req, 0);
        chk("rstmid_bus", {addr, wdata, wmask, wen}, 0);
        chk("rstmid_done", {done_valid, done_err, done_rdata}, 0);
        chk("rstmid_ready", cmd_ready, 1);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        run_vec(vecs[4]);

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
